// File: rtl/vote_pkg.sv
// Shared types and constants for the vote accumulator: FSM states, the layout
// of a result word and the positions of the sticky error flags.
package vote_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } vote_state_e;

  localparam int VOTES_LSB = 16;
  localparam int CLASS_LSB = 0;

  localparam int ERR_PROTO = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_FULL  = 2;

endpackage

// File: rtl/vote_result_ram.sv
// Simple dual-port result RAM: one synchronous write port and one registered
// read port. A same-address read and write returns the old word.
module vote_result_ram #(
  parameter int DEPTH_BIT = 13,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DEPTH_BIT-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en,
  input  logic [DEPTH_BIT-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_BIT];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is cleared; the array itself keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vote_accumulator.sv
// Counts per-tree class votes for each sample, resolves the majority class and
// stores one packed result word per sample; pass-through mode stores raw results.
module vote_accumulator
  import vote_pkg::*;
#(
  parameter int RES_WIDTH = 16,
  parameter int DEPTH_BIT = 13,
  parameter int NUM_CLASS = 8,
  parameter int TREE_BIT  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_buffer_rst,
  input  logic                   i_mode,
  input  logic [TREE_BIT-1:0]    i_n_trees,
  input  logic                   i_res_vld,
  input  logic [RES_WIDTH-1:0]   i_res_val,
  output logic                   o_ready,
  input  logic                   i_rd_en,
  input  logic [DEPTH_BIT+1:0]   i_rd_addr,
  output logic [31:0]            o_rd_data,
  output logic [DEPTH_BIT:0]     o_slot_cnt,
  output logic                   o_full,
  output logic [2:0]             o_err
);

  localparam int CLS_BIT = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int SLOT_W  = DEPTH_BIT + 1;

  vote_state_e           state_q, state_d;
  logic [TREE_BIT-1:0]   tree_cnt_q, tree_cnt_d;
  logic [TREE_BIT-1:0]   n_trees_q, n_trees_d;
  logic                  mode_q, mode_d;
  logic [TREE_BIT-1:0]   cnt_q [NUM_CLASS];
  logic [TREE_BIT-1:0]   cnt_d [NUM_CLASS];
  logic [CLS_BIT-1:0]    scan_idx_q, scan_idx_d;
  logic [CLS_BIT-1:0]    best_idx_q, best_idx_d;
  logic [TREE_BIT-1:0]   best_cnt_q, best_cnt_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [2:0]            err_q, err_d;
  logic                  pt_vld_q, pt_vld_d;
  logic [RES_WIDTH-1:0]  pt_val_q, pt_val_d;

  logic                  clear;
  logic                  accept;
  logic                  first_vote;
  logic                  eff_mode;
  logic [TREE_BIT-1:0]   eff_n;
  logic                  in_range;
  logic [CLS_BIT-1:0]    class_idx;
  logic                  vote_inc;
  logic [TREE_BIT:0]     tree_next;
  logic                  last_vote;
  logic                  scan_last;
  logic                  cnt_clr;
  logic                  wr_req;
  logic                  wr_en;
  logic [31:0]           wr_data;
  logic                  unused_addr_bits;

  assign clear      = rst | i_buffer_rst;
  assign o_ready    = (state_q == ACC);
  assign accept     = i_res_vld && o_ready && !clear;
  assign first_vote = (tree_cnt_q == '0);

  // Mode and tree count come straight from the inputs on a sample's first vote.
  assign eff_mode  = first_vote ? i_mode : mode_q;
  assign eff_n     = first_vote ? ((i_n_trees == '0) ? TREE_BIT'(1) : i_n_trees) : n_trees_q;
  assign in_range  = 32'(i_res_val) < 32'(NUM_CLASS);
  assign class_idx = i_res_val[CLS_BIT-1:0];
  assign vote_inc  = accept && !eff_mode && in_range;
  assign tree_next = {1'b0, tree_cnt_q} + 1'b1;
  assign last_vote = (tree_next == {1'b0, eff_n});
  assign scan_last = (scan_idx_q == CLS_BIT'(NUM_CLASS - 1));
  assign cnt_clr   = clear || (state_q == WRITE);

  assign o_full = slot_q[DEPTH_BIT];
  assign wr_req = (state_q == WRITE) || pt_vld_q;
  assign wr_en  = wr_req && !o_full && !clear;

  assign wr_data = (state_q == WRITE)
                 ? ((32'(16'(best_cnt_q)) << VOTES_LSB) | (32'(16'(best_idx_q)) << CLASS_LSB))
                 : (32'(16'(pt_val_q)) << CLASS_LSB);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASS; gi++) begin : g_vote_cnt
      assign cnt_d[gi] = cnt_clr ? '0
                       : (vote_inc && (class_idx == CLS_BIT'(gi)) && (cnt_q[gi] != '1))
                         ? cnt_q[gi] + 1'b1
                         : cnt_q[gi];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    tree_cnt_d = tree_cnt_q;
    n_trees_d  = n_trees_q;
    mode_d     = mode_q;
    scan_idx_d = scan_idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    slot_d     = slot_q;
    err_d      = err_q;
    pt_vld_d   = 1'b0;
    pt_val_d   = pt_val_q;

    if (clear) begin
      state_d    = ACC;
      tree_cnt_d = '0;
      n_trees_d  = '0;
      mode_d     = 1'b0;
      scan_idx_d = '0;
      best_idx_d = '0;
      best_cnt_d = '0;
      slot_d     = '0;
      err_d      = '0;
    end else begin
      if (i_res_vld && !o_ready) begin
        err_d[ERR_PROTO] = 1'b1;
      end
      if (wr_req && o_full) begin
        err_d[ERR_FULL] = 1'b1;
      end
      if (wr_en) begin
        slot_d = slot_q + 1'b1;
      end

      case (state_q)
        ACC: begin
          if (accept) begin
            if (first_vote) begin
              mode_d    = i_mode;
              n_trees_d = eff_n;
            end
            if (eff_mode) begin
              pt_vld_d = 1'b1;
              pt_val_d = i_res_val;
            end else begin
              if (!in_range) begin
                err_d[ERR_RANGE] = 1'b1;
              end
              tree_cnt_d = tree_next[TREE_BIT-1:0];
              if (last_vote) begin
                state_d = SCAN;
              end
            end
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (cnt_q[scan_idx_q] > best_cnt_q) begin
            best_cnt_d = cnt_q[scan_idx_q];
            best_idx_d = scan_idx_q;
          end
          if (scan_last) begin
            scan_idx_d = '0;
            state_d    = WRITE;
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
          end
        end
        WRITE: begin
          state_d    = ACC;
          tree_cnt_d = '0;
          best_cnt_d = '0;
          best_idx_d = '0;
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      tree_cnt_q <= '0;
      n_trees_q  <= '0;
      mode_q     <= 1'b0;
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      slot_q     <= '0;
      err_q      <= '0;
      pt_vld_q   <= 1'b0;
      pt_val_q   <= '0;
      for (int i = 0; i < NUM_CLASS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tree_cnt_q <= tree_cnt_d;
      n_trees_q  <= n_trees_d;
      mode_q     <= mode_d;
      scan_idx_q <= scan_idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      slot_q     <= slot_d;
      err_q      <= err_d;
      pt_vld_q   <= pt_vld_d;
      pt_val_q   <= pt_val_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_slot_cnt       = slot_q;
  assign o_err            = err_q;
  assign unused_addr_bits = ^i_rd_addr[1:0];

  vote_result_ram #(
    .DEPTH_BIT (DEPTH_BIT),
    .DATA_W    (32)
  ) u_ram (
    .clk     (clk),
    .rst     (clear),
    .wr_en   (wr_en),
    .wr_addr (slot_q[DEPTH_BIT-1:0]),
    .wr_data (wr_data),
    .rd_en   (i_rd_en),
    .rd_addr (i_rd_addr[DEPTH_BIT+1:2]),
    .rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_vote_accumulator.sv
// Directed bench: table of majority samples plus hand sequences for protocol
// errors, pass-through, mid-sample clear and the full condition.
module tb_vote_accumulator;

  localparam int DB   = 13;
  localparam int DB_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            a_buf_rst, a_mode, a_vld, a_ready, a_rd_en, a_full;
  logic [7:0]      a_n;
  logic [15:0]     a_val;
  logic [DB+1:0]   a_rd_addr;
  logic [31:0]     a_rd_data;
  logic [DB:0]     a_slot;
  logic [2:0]      a_err;

  logic            b_buf_rst, b_mode, b_vld, b_ready, b_rd_en, b_full;
  logic [7:0]      b_n;
  logic [15:0]     b_val;
  logic [DB_B+1:0] b_rd_addr;
  logic [31:0]     b_rd_data;
  logic [DB_B:0]   b_slot;
  logic [2:0]      b_err;

  int tests = 0;
  int fails = 0;

  vote_accumulator #(.RES_WIDTH(16), .DEPTH_BIT(DB), .NUM_CLASS(8), .TREE_BIT(8)) dut_a (
    .clk(clk), .rst(rst), .i_buffer_rst(a_buf_rst), .i_mode(a_mode), .i_n_trees(a_n),
    .i_res_vld(a_vld), .i_res_val(a_val), .o_ready(a_ready), .i_rd_en(a_rd_en),
    .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data), .o_slot_cnt(a_slot), .o_full(a_full),
    .o_err(a_err)
  );

  vote_accumulator #(.RES_WIDTH(16), .DEPTH_BIT(DB_B), .NUM_CLASS(8), .TREE_BIT(8)) dut_b (
    .clk(clk), .rst(rst), .i_buffer_rst(b_buf_rst), .i_mode(b_mode), .i_n_trees(b_n),
    .i_res_vld(b_vld), .i_res_val(b_val), .o_ready(b_ready), .i_rd_en(b_rd_en),
    .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data), .o_slot_cnt(b_slot), .o_full(b_full),
    .o_err(b_err)
  );

  typedef struct {
    logic [7:0]  n_trees;
    logic [15:0] votes [8];
    logic [31:0] exp_word;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_votes(input logic [7:0] n, input logic [7:0] n_after, input int nv,
                            input logic [15:0] v [8]);
    for (int k = 0; k < nv; k++) begin
      a_mode = 1'b0;
      a_n    = (k == 0) ? n : n_after;
      a_vld  = 1'b1;
      a_val  = v[k];
      @(negedge clk);
    end
    a_vld = 1'b0;
  endtask

  task automatic wait_ready_a(output int lows);
    lows = 0;
    while (!a_ready && lows < 100) begin
      lows++;
      @(negedge clk);
    end
    if (!a_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: o_ready still 0 after %0d cycles, required 1", lows);
    end
  endtask

  task automatic read_a(input int idx, output logic [31:0] d);
    a_rd_en   = 1'b1;
    a_rd_addr = (DB + 2)'(idx * 4 + 3);
    @(negedge clk);
    a_rd_en = 1'b0;
    d = a_rd_data;
  endtask

  task automatic read_b(input int idx, output logic [31:0] d);
    b_rd_en   = 1'b1;
    b_rd_addr = (DB_B + 2)'(idx * 4);
    @(negedge clk);
    b_rd_en = 1'b0;
    d = b_rd_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lows;
    int          nv;
    logic [31:0] d;
    logic [15:0] vv [8];
    logic [15:0] pt [3];

    vecs[0] = '{8'd5, '{16'd3, 16'd3, 16'd1, 16'd3, 16'd2, 16'd0, 16'd0, 16'd0}, 32'h0003_0003, 3'b000};
    vecs[1] = '{8'd4, '{16'd6, 16'd2, 16'd6, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0}, 32'h0002_0002, 3'b000};
    vecs[2] = '{8'd1, '{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'h0001_0005, 3'b000};
    vecs[3] = '{8'd0, '{16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'h0001_0007, 3'b000};
    vecs[4] = '{8'd3, '{16'd0, 16'd0, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'h0002_0000, 3'b000};
    vecs[5] = '{8'd6, '{16'd1, 16'd1, 16'd1, 16'd6, 16'd6, 16'd6, 16'd0, 16'd0}, 32'h0003_0001, 3'b000};
    vecs[6] = '{8'd3, '{16'd9, 16'd2, 16'd12, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'h0001_0002, 3'b010};
    vecs[7] = '{8'd2, '{16'd9, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'h0000_0000, 3'b010};

    a_buf_rst = 0; a_mode = 0; a_vld = 0; a_rd_en = 0; a_n = 0; a_val = 0; a_rd_addr = '0;
    b_buf_rst = 0; b_mode = 0; b_vld = 0; b_rd_en = 0; b_n = 0; b_val = 0; b_rd_addr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_slot", 32'(a_slot), 32'd0);
    check("rst_full", 32'(a_full), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_rd_data", a_rd_data, 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    check("rst_b_slot", 32'(b_slot), 32'd0);
    check("rst_b_full", 32'(b_full), 32'd0);

    for (int i = 0; i < 8; i++) begin
      nv = (vecs[i].n_trees == 8'd0) ? 1 : int'(vecs[i].n_trees);
      send_votes(vecs[i].n_trees, vecs[i].n_trees, nv, vecs[i].votes);
      wait_ready_a(lows);
      check($sformatf("vec%0d_ready_low", i), 32'(lows), 32'd9);
      read_a(i, d);
      check($sformatf("vec%0d_word", i), d, vecs[i].exp_word);
      check($sformatf("vec%0d_slot", i), 32'(a_slot), 32'(i + 1));
      check($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].exp_err));
      $display("[TB] vec %0d n=%0d word=0x%08h slot=%0d err=%03b", i, vecs[i].n_trees, d, a_slot, a_err);
    end

    @(negedge clk);
    check("rd_hold", a_rd_data, vecs[7].exp_word);

    // Tree count changes after the first vote must be ignored; vld in SCAN is dropped.
    vv = '{16'd4, 16'd4, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_votes(8'd3, 8'd7, 3, vv);
    a_vld = 1'b1;
    a_val = 16'd5;
    @(negedge clk);
    @(negedge clk);
    a_vld = 1'b0;
    wait_ready_a(lows);
    read_a(8, d);
    check("proto_word", d, 32'h0002_0004);
    check("proto_err", 32'(a_err), 32'b011);
    check("proto_slot", 32'(a_slot), 32'd9);
    $display("[TB] proto word=0x%08h err=%03b", d, a_err);

    pt = '{16'd7, 16'd1, 16'd4};
    a_n = 8'd5;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pt_ready%0d", k), 32'(a_ready), 32'd1);
      a_mode = 1'b1;
      a_vld  = 1'b1;
      a_val  = pt[k];
      @(negedge clk);
    end
    a_vld  = 1'b0;
    a_mode = 1'b0;
    check("pt_ready3", 32'(a_ready), 32'd1);
    @(negedge clk);
    check("pt_slot", 32'(a_slot), 32'd12);
    for (int k = 0; k < 3; k++) begin
      read_a(9 + k, d);
      check($sformatf("pt_word%0d", k), d, 32'(pt[k]));
      $display("[TB] pt %0d word=0x%08h", k, d);
    end

    vv = '{16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_votes(8'd5, 8'd5, 2, vv);
    a_vld     = 1'b1;
    a_val     = 16'd1;
    a_buf_rst = 1'b1;
    @(negedge clk);
    a_vld     = 1'b0;
    a_buf_rst = 1'b0;
    check("clr_slot", 32'(a_slot), 32'd0);
    check("clr_err", 32'(a_err), 32'd0);
    check("clr_ready", 32'(a_ready), 32'd1);
    vv = '{16'd1, 16'd3, 16'd3, 16'd1, 16'd3, 16'd0, 16'd0, 16'd0};
    send_votes(8'd5, 8'd5, 5, vv);
    wait_ready_a(lows);
    check("clr_ready_low", 32'(lows), 32'd9);
    read_a(0, d);
    check("clr_word", d, 32'h0003_0003);
    check("clr_slot_after", 32'(a_slot), 32'd1);
    $display("[TB] clear word=0x%08h slot=%0d", d, a_slot);

    b_mode = 1'b1;
    b_n    = 8'd1;
    for (int k = 0; k < 4; k++) begin
      b_vld = 1'b1;
      b_val = 16'(10 + k);
      @(negedge clk);
    end
    b_vld = 1'b0;
    check("full_before4", 32'(b_full), 32'd0);
    check("slot_before4", 32'(b_slot), 32'd3);
    @(negedge clk);
    check("full_after4", 32'(b_full), 32'd1);
    check("slot_after4", 32'(b_slot), 32'd4);
    check("err_after4", 32'(b_err), 32'd0);
    check("b_ready_full", 32'(b_ready), 32'd1);
    b_vld = 1'b1;
    b_val = 16'd14;
    @(negedge clk);
    b_vld = 1'b0;
    @(negedge clk);
    check("full_err", 32'(b_err), 32'b100);
    check("full_slot", 32'(b_slot), 32'd4);
    check("full_flag", 32'(b_full), 32'd1);
    read_b(3, d);
    check("full_mem3", d, 32'd13);
    read_b(0, d);
    check("full_mem0", d, 32'd10);
    $display("[TB] full slot=%0d err=%03b", b_slot, b_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
